// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared definitions for the CNN streaming blocks: a width
//                helper that never returns less than one bit, and the state
//                type of the channel serializer's read FSM.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // $clog2 clamped to at least 1 so that degenerate sizes still give a
    // legal vector width.
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/vector_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vector_fifo
//  Description : Register FIFO of Depth entries, each one complete pixel
//                vector. Depth need not be a power of two; pointers wrap
//                explicitly. A push into a full FIFO is accepted only when a
//                pop happens in the same cycle.
//  Ports       : clk, res_n      - clock, async active-low reset
//                push_i, din_i   - write request and vector
//                pop_i           - drop the head entry (only when non-empty)
//                head_o, next_o  - oldest and second-oldest entries
//                count_o, full_o - occupancy and full flag
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_fifo
    import cnn_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 64
) (
    input  logic                           clk,
    input  logic                           res_n,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [Width-1:0]               din_i,
    output logic [Width-1:0]               head_o,
    output logic [Width-1:0]               next_o,
    output logic [clog2_min1(Depth+1)-1:0] count_o,
    output logic                           full_o
);
    localparam int PW = clog2_min1(Depth);
    localparam int CW = clog2_min1(Depth + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic             wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    // When full, the slot being written is the head being popped this cycle.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_next = ptr_inc(rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next];

    // Storage carries no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_next;
            end
            case ({wr_en, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_channel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pool_channel_serializer
//  Description : Gathers per-kernel pooled values arriving on shared PE lanes
//                into complete pixel vectors, buffers them in a vector FIFO
//                and replays each vector as a channel-ordered single-lane
//                ready/valid stream.
//  Ports       : clk, res_n             - clock, async active-low reset
//                in_valid, in_data      - per-channel strobes, lane data
//                out_ready, out_valid   - output handshake
//                out_data, out_channel  - channel value and index
//                out_last               - final channel of a vector
//                fifo_count             - stored complete vectors
//                overflow, collision    - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_channel_serializer
    import cnn_pkg::*;
#(
    parameter int NumberOfK          = 8,
    parameter int ProcessingElements = 2,
    parameter int BitSize            = 8,
    parameter int Depth              = 4
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic [NumberOfK-1:0]                  in_valid,
    input  logic [ProcessingElements*BitSize-1:0] in_data,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [BitSize-1:0]                    out_data,
    output logic [clog2_min1(NumberOfK)-1:0]      out_channel,
    output logic                                  out_last,
    output logic [clog2_min1(Depth+1)-1:0]        fifo_count,
    output logic                                  overflow,
    output logic                                  collision
);
    localparam int CHW  = clog2_min1(NumberOfK);
    localparam int CNTW = clog2_min1(Depth + 1);
    localparam int VW   = NumberOfK * BitSize;
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NumberOfK - 1);
    localparam logic [CHW-1:0]  FIRST_CH = '0;
    localparam logic [CNTW-1:0] ONE_VEC = CNTW'(1);

    logic [VW-1:0]        asm_data_q, asm_data_d;
    logic [NumberOfK-1:0] asm_mask_q, asm_mask_d;
    logic                 complete;
    logic                 overflow_q, collision_q;

    logic                 fifo_full, fifo_pop;
    logic [VW-1:0]        head_vec, next_vec;
    logic [CNTW-1:0]      count;

    ser_state_t           state_q;
    logic                 out_valid_q;
    logic [BitSize-1:0]   out_data_q;
    logic [CHW-1:0]       out_channel_q;
    logic                 out_last_q;

    function automatic logic [BitSize-1:0] word_of(input logic [VW-1:0] v,
                                                   input logic [CHW-1:0] c);
        return v[int'(c)*BitSize +: BitSize];
    endfunction

    // Merge this cycle's strobes over the held partial vector. Strobes in the
    // completing cycle are part of the pushed vector, so the FIFO is fed from
    // the merged value rather than the register.
    always_comb begin
        asm_data_d = asm_data_q;
        for (int k = 0; k < NumberOfK; k++) begin
            if (in_valid[k]) begin
                asm_data_d[k*BitSize +: BitSize] =
                    in_data[(k % ProcessingElements)*BitSize +: BitSize];
            end
        end
        complete   = &(asm_mask_q | in_valid);
        asm_mask_d = complete ? '0 : (asm_mask_q | in_valid);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            asm_data_q  <= '0;
            asm_mask_q  <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_mask_q <= asm_mask_d;
            if (|(in_valid & asm_mask_q)) begin
                collision_q <= 1'b1;
            end
            if (complete && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign fifo_pop = (state_q == EMIT) && out_valid_q && out_ready &&
                      (out_channel_q == LAST_CH);

    vector_fifo #(
        .Depth (Depth),
        .Width (VW)
    ) u_vector_fifo (
        .clk     (clk),
        .res_n   (res_n),
        .push_i  (complete),
        .pop_i   (fifo_pop),
        .din_i   (asm_data_d),
        .head_o  (head_vec),
        .next_o  (next_vec),
        .count_o (count),
        .full_o  (fifo_full)
    );

    // Read FSM. Output words are loaded one cycle ahead of acceptance; on the
    // final word the next vector (second FIFO entry) is preloaded so that
    // stored vectors stream without a bubble.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        state_q       <= EMIT;
                        out_valid_q   <= 1'b1;
                        out_channel_q <= FIRST_CH;
                        out_data_q    <= word_of(head_vec, FIRST_CH);
                        out_last_q    <= (LAST_CH == FIRST_CH);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_channel_q == LAST_CH) begin
                            if (count > ONE_VEC) begin
                                out_channel_q <= FIRST_CH;
                                out_data_q    <= word_of(next_vec, FIRST_CH);
                                out_last_q    <= (LAST_CH == FIRST_CH);
                            end else begin
                                state_q       <= IDLE;
                                out_valid_q   <= 1'b0;
                                out_data_q    <= '0;
                                out_channel_q <= '0;
                                out_last_q    <= 1'b0;
                            end
                        end else begin
                            out_channel_q <= out_channel_q + CHW'(1);
                            out_data_q    <= word_of(head_vec, out_channel_q + CHW'(1));
                            out_last_q    <= ((out_channel_q + CHW'(1)) == LAST_CH);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_last    = out_last_q;
    assign fifo_count  = count;
    assign overflow    = overflow_q;
    assign collision   = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_channel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_channel_serializer
//  Description : Self-checking bench for pool_channel_serializer. A queue-based
//                reference model (partial vector, list of stored vectors,
//                position in the head vector) tracks every cycle; a fixed
//                table pins the exact first-vector timing, and short directed
//                sequences cover overflow, stalls, collisions and reset.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_channel_serializer;
    localparam int K     = 8;
    localparam int PE    = 2;
    localparam int BW    = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              res_n;
    logic [K-1:0]      in_valid;
    logic [PE*BW-1:0]  in_data;
    logic              out_ready;
    logic              out_valid;
    logic [BW-1:0]     out_data;
    logic [2:0]        out_channel;
    logic              out_last;
    logic [2:0]        fifo_count;
    logic              overflow;
    logic              collision;

    pool_channel_serializer #(
        .NumberOfK          (K),
        .ProcessingElements (PE),
        .BitSize            (BW),
        .Depth              (DEPTH)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_last    (out_last),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [K-1:0]    m_mask;
    logic [K*BW-1:0] m_asm;
    logic [K*BW-1:0] m_q[$];
    int              m_ch;
    bit              m_ovf, m_col;
    bit              p_stall;
    logic [BW-1:0]   p_data;
    logic [2:0]      p_ch;
    logic            p_last;
    logic [2:0]      cap_ch[$];
    logic [BW-1:0]   cap_data[$];

    task automatic model_reset();
        m_mask  = '0;
        m_asm   = '0;
        m_q.delete();
        m_ch    = 0;
        m_ovf   = 0;
        m_col   = 0;
        p_stall = 0;
    endtask

    task automatic clear_cap();
        cap_ch.delete();
        cap_data.delete();
    endtask

    // Called at a falling edge: check settled outputs against the model,
    // advance the model by what the coming rising edge will do, drive inputs.
    task automatic tick(input logic [K-1:0] v, input logic [PE*BW-1:0] d, input logic r);
        logic [K*BW-1:0] head;
        bit acc;
        chk("fifo_count", fifo_count, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("collision", collision, m_col);
        if (p_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, p_data);
            chk("stall_channel", out_channel, p_ch);
            chk("stall_last", out_last, p_last);
        end
        if (out_valid) begin
            if (m_q.size() == 0) begin
                chk("word_without_vector", out_valid, 1'b0);
            end else begin
                head = m_q[0];
                chk("word_channel", out_channel, m_ch);
                chk("word_data", out_data, head[m_ch*BW +: BW]);
                chk("word_last", out_last, m_ch == K-1);
            end
        end else begin
            chk("idle_last", out_last, 1'b0);
        end
        acc = out_valid && r;
        if (acc) begin
            cap_ch.push_back(out_channel);
            cap_data.push_back(out_data);
            if (m_q.size() > 0) begin
                if (m_ch == K-1) begin
                    void'(m_q.pop_front());
                    m_ch = 0;
                end else begin
                    m_ch++;
                end
            end
        end
        for (int k = 0; k < K; k++) begin
            if (v[k]) begin
                if (m_mask[k]) m_col = 1;
                m_mask[k] = 1'b1;
                m_asm[k*BW +: BW] = d[(k % PE)*BW +: BW];
            end
        end
        if (&m_mask) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_asm);
            else m_ovf = 1;
            m_mask = '0;
        end
        p_stall = out_valid && !r;
        p_data  = out_data;
        p_ch    = out_channel;
        p_last  = out_last;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input bit toggle, input string name);
        int n;
        bit r;
        n = 0;
        r = 1'b1;
        while ((m_q.size() != 0 || out_valid) && n < budget) begin
            tick('0, '0, r);
            if (toggle) r = ~r;
            n++;
        end
        chk({name, "_drained"}, (m_q.size() != 0) || out_valid, 1'b0);
    endtask

    // ---------------- first-vector timing table ----------------
    typedef struct {
        logic [K-1:0]     v;
        logic [PE*BW-1:0] d;
        logic             r;
        logic             e_valid;
        logic [2:0]       e_ch;
        logic [BW-1:0]    e_data;
        logic             e_last;
        logic [2:0]       e_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // lanes given as {lane1, lane0}; even channels take lane 0
        tbl[0]  = '{8'h03, 16'h1122, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{8'h0C, 16'h3344, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};
        tbl[2]  = '{8'h30, 16'h5566, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};
        tbl[3]  = '{8'hC0, 16'h7788, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1};
        tbl[4]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd0, 8'h22, 1'b0, 3'd1};
        tbl[5]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd1, 8'h11, 1'b0, 3'd1};
        tbl[6]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd2, 8'h44, 1'b0, 3'd1};
        tbl[7]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd3, 8'h33, 1'b0, 3'd1};
        tbl[8]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd4, 8'h66, 1'b0, 3'd1};
        tbl[9]  = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd5, 8'h55, 1'b0, 3'd1};
        tbl[10] = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd6, 8'h88, 1'b0, 3'd1};
        tbl[11] = '{8'h00, 16'h0000, 1'b1, 1'b1, 3'd7, 8'h77, 1'b1, 3'd1};
        tbl[12] = '{8'h00, 16'h0000, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};

        res_n = 1'b0;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        model_reset();
        clear_cap();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_channel", out_channel, 3'd0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_collision", collision, 1'b0);
        res_n = 1'b1;
        @(negedge clk);

        // exact latency and ordering of one vector
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_channel", i), out_channel, tbl[i].e_ch);
                chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_last", i), out_last, tbl[i].e_last);
            end
        end

        // all channels in one cycle, two strobes per lane
        clear_cap();
        tick(8'hFF, 16'hAA55, 1'b1);
        drain(40, 1'b0, "allch");
        chk("allch_words", cap_data.size(), 8);
        for (int k = 0; k < 8 && k < cap_data.size(); k++)
            chk($sformatf("allch_data%0d", k), cap_data[k], (k % 2 == 0) ? 8'h55 : 8'hAA);
        chk("allch_collision", collision, 1'b0);

        // five vectors against a stalled output: fifth is dropped
        clear_cap();
        for (int i = 0; i < 5; i++) tick(8'hFF, 16'($urandom), 1'b0);
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        drain(60, 1'b0, "ovf");
        chk("ovf_words", cap_data.size(), 32);

        // ready toggling every cycle
        clear_cap();
        tick(8'h0F, 16'($urandom), 1'b1);
        tick(8'hF0, 16'($urandom), 1'b1);
        drain(40, 1'b1, "toggle");
        chk("toggle_words", cap_ch.size(), 8);
        for (int k = 0; k < 8 && k < cap_ch.size(); k++)
            chk($sformatf("toggle_ch%0d", k), cap_ch[k], k);

        // channel 3 strobed twice before completion
        clear_cap();
        tick(8'h08, 16'h1000, 1'b1);
        tick(8'h08, 16'h2000, 1'b1);
        chk("col_set", collision, 1'b1);
        tick(8'hF7, 16'($urandom), 1'b1);
        drain(40, 1'b0, "col");
        chk("col_words", cap_data.size(), 8);
        if (cap_data.size() > 3) chk("col_ch3", cap_data[3], 8'h20);

        // reset in the middle of a vector
        clear_cap();
        tick(8'hFF, 16'($urandom), 1'b1);
        n = 0;
        while (!(out_valid && out_channel == 3'd4) && n < 20) begin
            tick('0, '0, 1'b1);
            n++;
        end
        chk("mid_reach_ch4", out_channel, 3'd4);
        #2 res_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_channel", out_channel, 3'd0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_collision", collision, 1'b0);
        model_reset();
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        clear_cap();
        tick(8'hFF, 16'hC33C, 1'b1);
        drain(40, 1'b0, "post_rst");
        chk("post_rst_words", cap_data.size(), 8);
        if (cap_data.size() > 1) begin
            chk("post_rst_ch0", cap_ch[0], 3'd0);
            chk("post_rst_data0", cap_data[0], 8'h3C);
            chk("post_rst_data1", cap_data[1], 8'hC3);
        end

        // random strobes and back-pressure against the model
        for (int i = 0; i < 400; i++)
            tick(8'($urandom) & 8'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
        drain(300, 1'b0, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
